// File: rtl/stage_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : stage_if_prefetch
// Purpose  : Instruction fetch stage with a decoupled imem port and a
//            DEPTH-entry prefetch queue feeding ID via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module stage_if_prefetch #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    WORD_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jmp_bch_en,
  input  logic [ADDR_WIDTH-1:0] jmp_bch_tgt,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] imem_rsp_data,
  input  logic                  id_ready,
  output logic                  inst_valid,
  output logic [WORD_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc_addr
);

  localparam int                    c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                    c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W:0]      c_CREDIT = (c_CNT_W + 1)'(DEPTH);
  localparam logic [WORD_WIDTH-1:0] c_NOP    = WORD_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] c_STEP   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN  = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [ADDR_WIDTH-1:0] r_q_pc   [DEPTH];
  logic [WORD_WIDTH-1:0] r_q_inst [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    r_outstanding;
  logic [c_CNT_W-1:0]    r_drop;

  logic                  w_credit_ok;
  logic                  w_req_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [c_CNT_W-1:0]    w_out_after_rsp;
  logic [ADDR_WIDTH-1:0] w_tgt;

  // Queued entries plus in-flight requests never exceed DEPTH, so a
  // response always finds a free slot.
  assign w_credit_ok     = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_CREDIT;
  assign imem_req_valid  = !rst && !jmp_bch_en && w_credit_ok;
  assign imem_req_addr   = r_fetch_pc;
  assign w_req_fire      = imem_req_valid && imem_req_ready;
  assign w_push          = !rst && imem_rsp_valid && !jmp_bch_en && (r_drop == '0);
  assign w_pop           = inst_valid && id_ready && !jmp_bch_en;
  assign w_out_after_rsp = r_outstanding - c_CNT_W'(imem_rsp_valid);
  assign w_tgt           = jmp_bch_tgt & c_ALIGN;

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_q_inst[r_head] : c_NOP;
  assign pc_addr    = inst_valid ? r_q_pc[r_head]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_rsp_pc      <= RESET_VECTOR;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);
      if (jmp_bch_en) begin
        // Everything still in flight now belongs to the abandoned path.
        r_fetch_pc <= w_tgt;
        r_rsp_pc   <= w_tgt;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_drop     <= w_out_after_rsp;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + c_STEP;
        end
        if (imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - c_CNT_W'(1);
        end
        if (w_push) begin
          r_tail   <= r_tail + c_PTR_W'(1);
          r_rsp_pc <= r_rsp_pc + c_STEP;
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_tail] <= imem_rsp_data;
      r_q_pc[r_tail]   <= r_rsp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_if_prefetch
// Purpose  : Directed self-checking bench for stage_if_prefetch with an
//            in-order, fixed-latency instruction memory model (data = ~addr).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_if_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jmp_bch_en = 1'b0;
  logic [31:0] jmp_bch_tgt = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_ready = 1'b1;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_addr;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] out_pc[$];
  logic [31:0] out_inst[$];

  stage_if_prefetch #(
    .ADDR_WIDTH  (32),
    .WORD_WIDTH  (32),
    .DEPTH       (4),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jmp_bch_en    (jmp_bch_en),
    .jmp_bch_tgt   (jmp_bch_tgt),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_ready      (id_ready),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc_addr       (pc_addr)
  );

  always #5 clk = ~clk;

  // Memory: requests accepted in cycle c answer in cycle c+lat, in order.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    if (rst) begin
      pend.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pend.push_back('{imem_req_addr, cyc + lat});
      acc_log.push_back(imem_req_addr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the start of the first cycle after rst deasserts.
  task automatic do_reset();
    cycle();
    rst        = 1'b1;
    jmp_bch_en = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and streaming with L=1
    cycle(); cycle(); look();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_pc", pc_addr, 32'h0);
    cycle(); rst = 1'b0; look();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    chk("first_inst_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("c2_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("c2_req_addr", imem_req_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      cycle(); look();
      chk("stream_valid", {31'b0, inst_valid}, 32'h1);
      chk("stream_pc", pc_addr, 32'(i * 4));
      chk("stream_inst", inst, ~32'(i * 4));
    end

    // Back-pressure fills the queue, then drains in order
    id_ready = 1'b0; lat = 1;
    do_reset(); acc_log.delete(); look();
    repeat (9) cycle();
    look();
    chk("fill_accepts", 32'(acc_log.size()), 32'd4);
    chk("fill_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("fill_head_valid", {31'b0, inst_valid}, 32'h1);
    for (int i = 0; i < 4; i++) chk("fill_acc_addr", acc_log[i], 32'(i * 4));
    cycle(); id_ready = 1'b1; look();
    chk("drain_pc0", pc_addr, 32'h0);
    chk("drain_full_no_req", {31'b0, imem_req_valid}, 32'h0);
    cycle(); look();
    chk("drain_pc4", pc_addr, 32'h4);
    chk("resume_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("resume_req_addr", imem_req_addr, 32'h10);
    cycle(); look();
    chk("drain_pc8", pc_addr, 32'h8);
    cycle(); look();
    chk("drain_pcC", pc_addr, 32'hC);
    chk("drain_instC", inst, ~32'hC);
    cycle(); look();
    chk("resume_pc10", pc_addr, 32'h10);
    chk("resume_inst10", inst, ~32'h10);

    // L=3, redirect with three requests in flight
    id_ready = 1'b1; lat = 3;
    do_reset(); look();
    chk("l3_req0", imem_req_addr, 32'h0);
    cycle(); cycle();
    cycle(); jmp_bch_en = 1'b1; jmp_bch_tgt = 32'h100; look();
    chk("l3_redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    cycle(); jmp_bch_en = 1'b0; look();
    chk("l3_t1_valid", {31'b0, inst_valid}, 32'h0);
    chk("l3_t1_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("l3_t1_req_addr", imem_req_addr, 32'h100);
    cycle(); look();
    chk("l3_t2_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("l3_t3_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("l3_t4_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("l3_t5_valid", {31'b0, inst_valid}, 32'h1);
    chk("l3_t5_pc", pc_addr, 32'h100);
    chk("l3_t5_inst", inst, ~32'h100);
    cycle(); look();
    chk("l3_t6_pc", pc_addr, 32'h104);

    // Redirect coinciding with a response and a pop on a loaded queue
    id_ready = 1'b0; lat = 1;
    do_reset(); look();
    repeat (4) cycle();
    jmp_bch_en = 1'b1; jmp_bch_tgt = 32'h200; id_ready = 1'b1; look();
    chk("rj_head_valid", {31'b0, inst_valid}, 32'h1);
    chk("rj_head_pc", pc_addr, 32'h0);
    chk("rj_rsp_present", {31'b0, imem_rsp_valid & ~imem_req_valid}, 32'h1);
    cycle(); jmp_bch_en = 1'b0; look();
    chk("rj_empty_valid", {31'b0, inst_valid}, 32'h0);
    chk("rj_empty_inst", inst, 32'h0000_0013);
    chk("rj_empty_pc", pc_addr, 32'h0);
    chk("rj_req_addr", imem_req_addr, 32'h200);
    cycle(); look();
    chk("rj_t2_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("rj_t3_pc", pc_addr, 32'h200);
    chk("rj_t3_inst", inst, ~32'h200);
    cycle(); look();
    chk("rj_t4_pc", pc_addr, 32'h204);

    // Address wrap under random request back-pressure
    id_ready = 1'b1; lat = 1; imem_req_ready = 1'b1;
    do_reset(); look();
    cycle(); jmp_bch_en = 1'b1; jmp_bch_tgt = 32'hFFFF_FFFB; look();
    chk("wrap_redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    acc_log.delete();
    cycle(); jmp_bch_en = 1'b0; imem_req_ready = 1'b0; look();
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 24; i++) begin
      cycle();
      imem_req_ready = (i < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
      look();
      if (inst_valid) begin
        out_pc.push_back(pc_addr);
        out_inst.push_back(inst);
      end
    end
    chk("wrap_accepts_ge3", {31'b0, acc_log.size() >= 3}, 32'h1);
    chk("wrap_heads_ge3", {31'b0, out_pc.size() >= 3}, 32'h1);
    chk("wrap_acc0", acc_log[0], 32'hFFFF_FFF8);
    chk("wrap_acc1", acc_log[1], 32'hFFFF_FFFC);
    chk("wrap_acc2", acc_log[2], 32'h0);
    chk("wrap_pc0", out_pc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", out_pc[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", out_pc[2], 32'h0);
    chk("wrap_inst1", out_inst[1], 32'h0000_0003);

    // Asynchronous reset with a half-full queue
    id_ready = 1'b0; lat = 1; imem_req_ready = 1'b1;
    do_reset(); look();
    cycle(); cycle();
    cycle(); look();
    chk("hr_pre_valid", {31'b0, inst_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("hr_valid", {31'b0, inst_valid}, 32'h0);
    chk("hr_inst", inst, 32'h0000_0013);
    chk("hr_pc", pc_addr, 32'h0);
    chk("hr_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("hr_req_addr", imem_req_addr, 32'h0);
    cycle(); cycle(); rst = 1'b0; id_ready = 1'b1; look();
    chk("hr_restart_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("hr_restart_addr", imem_req_addr, 32'h0);
    cycle(); look();
    chk("hr_t1_valid", {31'b0, inst_valid}, 32'h0);
    cycle(); look();
    chk("hr_t2_pc", pc_addr, 32'h0);
    chk("hr_t2_inst", inst, 32'hFFFF_FFFF);
    cycle(); look();
    chk("hr_t3_pc", pc_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
